// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between the requesters, the arbiter and the FIFO write side.
// Lane i data sits at req_data[i], i.e. bits [i*dwidth +: dwidth] of the flat bus.
interface fifo_wr_arbiter_if #(
  parameter int nreq   = 4,
  parameter int dwidth = 8
);
  logic [nreq-1:0]             req_valid;
  logic [nreq-1:0]             req_last;
  logic [nreq-1:0][dwidth-1:0] req_data;
  logic                        full;
  logic [nreq-1:0]             req_ready;
  logic                        w_en;
  logic [dwidth-1:0]           wr_data;
  logic [nreq-1:0]             grant;
  logic                        busy;
  logic                        burst_err;

  // master: requesters + FIFO flag source; slave: the arbiter
  modport master (
    output req_valid, req_last, req_data, full,
    input  req_ready, w_en, wr_data, grant, busy, burst_err
  );
  modport slave (
    input  req_valid, req_last, req_data, full,
    output req_ready, w_en, wr_data, grant, busy, burst_err
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Packet-granular round-robin arbiter sharing the async FIFO write port.
// A grant ends on last or after max_burst words; full gates writes in-cycle.
module fifo_wr_arbiter_lane #(
  parameter int dwidth = 8
) (
  input  logic              grant,
  input  logic              valid,
  input  logic              full,
  input  logic [dwidth-1:0] data,
  output logic              ready,
  output logic              wr,
  output logic [dwidth-1:0] data_out
);
  assign ready    = grant & ~full;
  assign wr       = grant & valid & ~full;
  assign data_out = grant ? data : '0;
endmodule

module fifo_wr_arbiter #(
  parameter int nreq      = 4,
  parameter int dwidth    = 8,
  parameter int max_burst = 16
) (
  input  logic w_clk,
  input  logic w_rst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int pw = (nreq > 1) ? $clog2(nreq) : 1;
  localparam int cw = $clog2(max_burst + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                      state;
  logic [nreq-1:0]             grant_q;
  logic [pw-1:0]               rr_ptr;
  logic [cw-1:0]               cnt;
  logic                        berr_q;

  logic [nreq-1:0]             lane_ready;
  logic [nreq-1:0]             lane_wr;
  logic [nreq-1:0][dwidth-1:0] lane_data;
  logic [dwidth-1:0]           wdata;
  logic [pw-1:0]               gidx;
  logic [pw-1:0]               pick;
  logic [pw-1:0]               next_ptr;
  logic                        w_en;
  logic                        last_g;
  logic                        hit_limit;

  // grant_q is zero outside BUSY, so every lane output is quiet when idle
  for (genvar i = 0; i < nreq; i++) begin : g_lane
    fifo_wr_arbiter_lane #(.dwidth(dwidth)) u_lane (
      .grant    (grant_q[i]),
      .valid    (bus.req_valid[i]),
      .full     (bus.full),
      .data     (bus.req_data[i]),
      .ready    (lane_ready[i]),
      .wr       (lane_wr[i]),
      .data_out (lane_data[i])
    );
  end

  always_comb begin
    wdata = '0;
    for (int i = 0; i < nreq; i++) wdata |= lane_data[i];
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < nreq; i++)
      if (grant_q[i]) gidx = pw'(i);
  end

  // first valid requester at or after rr_ptr, wrapping modulo nreq
  always_comb begin
    logic found;
    int   idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < nreq; k++) begin
      idx = (int'(rr_ptr) + k) % nreq;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        pick  = pw'(idx);
      end
    end
  end

  assign w_en      = |lane_wr;
  assign last_g    = bus.req_last[gidx];
  assign hit_limit = (int'(cnt) + 1 == max_burst);
  assign next_ptr  = (int'(gidx) == nreq - 1) ? '0 : gidx + pw'(1);

  always_ff @(posedge w_clk or negedge w_rst) begin
    if (!w_rst) begin
      state   <= IDLE;
      grant_q <= '0;
      rr_ptr  <= '0;
      cnt     <= '0;
      berr_q  <= 1'b0;
    end else begin
      berr_q <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            grant_q <= nreq'(1) << pick;
            cnt     <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (w_en) begin
            cnt <= cnt + cw'(1);
            // last wins over the limit: a packet ending exactly at max_burst is not an error
            if (last_g || hit_limit) begin
              state   <= IDLE;
              grant_q <= '0;
              rr_ptr  <= next_ptr;
              berr_q  <= ~last_g;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = lane_ready;
  assign bus.w_en      = w_en;
  assign bus.wr_data   = wdata;
  assign bus.grant     = grant_q;
  assign bus.busy      = (state == BUSY);
  assign bus.burst_err = berr_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed, table-driven bench for fifo_wr_arbiter (nreq=4, dwidth=8, max_burst=4).
// Each vector is one cycle: inputs driven after negedge, outputs compared 1 time unit later.
module tb_fifo_wr_arbiter;
  logic w_clk = 1'b0;
  logic w_rst = 1'b0;

  fifo_wr_arbiter_if #(.nreq(4), .dwidth(8)) bus ();

  fifo_wr_arbiter #(.nreq(4), .dwidth(8), .max_burst(4)) dut (
    .w_clk (w_clk),
    .w_rst (w_rst),
    .bus   (bus)
  );

  always #5 w_clk = ~w_clk;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic        full;
    logic [31:0] data;
    logic [3:0]  grant;
    logic        busy;
    logic        w_en;
    logic [3:0]  ready;
    logic [7:0]  wdata;
    logic        berr;
  } vec_t;

  vec_t q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic add_idle(input logic [3:0] valid, input logic [3:0] last,
                          input logic [31:0] data, input logic berr);
    vec_t v;
    v.valid = valid; v.last = last; v.full = 1'b0; v.data = data;
    v.grant = 4'b0; v.busy = 1'b0; v.w_en = 1'b0; v.ready = 4'b0;
    v.wdata = 8'h00; v.berr = berr;
    q.push_back(v);
  endtask

  task automatic add_busy(input logic [3:0] valid, input logic [3:0] last, input logic full,
                          input logic [31:0] data, input logic [3:0] grant,
                          input logic w_en, input logic [7:0] wdata);
    vec_t v;
    v.valid = valid; v.last = last; v.full = full; v.data = data;
    v.grant = grant; v.busy = 1'b1; v.w_en = w_en;
    v.ready = full ? 4'b0 : grant;
    v.wdata = wdata; v.berr = 1'b0;
    q.push_back(v);
  endtask

  task automatic drive(input logic [3:0] valid, input logic [3:0] last,
                       input logic full, input logic [31:0] data);
    bus.req_valid = valid;
    bus.req_last  = last;
    bus.full      = full;
    bus.req_data  = data;
  endtask

  task automatic check_outs(input string nm, input logic [3:0] grant, input logic busy,
                            input logic w_en, input logic [3:0] ready,
                            input logic [7:0] wdata, input logic berr);
    chk({nm, " grant"},     32'(bus.grant),     32'(grant));
    chk({nm, " busy"},      32'(bus.busy),      32'(busy));
    chk({nm, " w_en"},      32'(bus.w_en),      32'(w_en));
    chk({nm, " req_ready"}, 32'(bus.req_ready), 32'(ready));
    chk({nm, " wr_data"},   32'(bus.wr_data),   32'(wdata));
    chk({nm, " burst_err"}, 32'(bus.burst_err), 32'(berr));
  endtask

  task automatic run(input string seg);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge w_clk);
      drive(q[i].valid, q[i].last, q[i].full, q[i].data);
      #1;
      check_outs($sformatf("%s[%0d]", seg, i), q[i].grant, q[i].busy, q[i].w_en,
                 q[i].ready, q[i].wdata, q[i].berr);
    end
    q.delete();
  endtask

  initial begin
    // reset state with live requests on the bus
    drive(4'b1111, 4'b0000, 1'b0, 32'h31_21_11_01);
    #3;
    check_outs("reset", 4'b0, 1'b0, 1'b0, 4'b0, 8'h00, 1'b0);
    @(negedge w_clk);
    drive(4'b0000, 4'b0000, 1'b0, 32'h0);
    w_rst = 1'b1;

    // single requester 2, three-word packet
    add_idle(4'b0100, 4'b0000, 32'h00_A1_00_00, 1'b0);
    add_busy(4'b0100, 4'b0000, 1'b0, 32'h00_A1_00_00, 4'b0100, 1'b1, 8'hA1);
    add_busy(4'b0100, 4'b0000, 1'b0, 32'h00_A2_00_00, 4'b0100, 1'b1, 8'hA2);
    add_busy(4'b0100, 4'b0100, 1'b0, 32'h00_A3_00_00, 4'b0100, 1'b1, 8'hA3);
    add_idle(4'b0000, 4'b0000, 32'h0, 1'b0);
    run("single");

    // async reset mid-packet (rr_ptr is 3 here)
    @(negedge w_clk);
    drive(4'b1000, 4'b0000, 1'b0, 32'hA0_00_00_00);
    #1 check_outs("rst_pre", 4'b0, 1'b0, 1'b0, 4'b0, 8'h00, 1'b0);
    @(negedge w_clk);
    #1 check_outs("rst_busy", 4'b1000, 1'b1, 1'b1, 4'b1000, 8'hA0, 1'b0);
    @(posedge w_clk);
    #2 w_rst = 1'b0;
    #1 check_outs("rst_mid", 4'b0, 1'b0, 1'b0, 4'b0, 8'h00, 1'b0);
    @(negedge w_clk);
    w_rst = 1'b1;
    drive(4'b0000, 4'b0000, 1'b0, 32'h0);

    // round robin after reset: must start at requester 0, not 3
    add_idle(4'b1111, 4'b0000, 32'h31_21_11_01, 1'b0);
    add_busy(4'b1111, 4'b0000, 1'b0, 32'h31_21_11_01, 4'b0001, 1'b1, 8'h01);
    add_busy(4'b1111, 4'b0001, 1'b0, 32'h31_21_11_02, 4'b0001, 1'b1, 8'h02);
    add_idle(4'b1111, 4'b0000, 32'h31_21_11_01, 1'b0);
    add_busy(4'b1111, 4'b0000, 1'b0, 32'h31_21_11_01, 4'b0010, 1'b1, 8'h11);
    add_busy(4'b1111, 4'b0010, 1'b0, 32'h31_21_12_01, 4'b0010, 1'b1, 8'h12);
    add_idle(4'b1111, 4'b0000, 32'h31_21_11_01, 1'b0);
    add_busy(4'b1111, 4'b0000, 1'b0, 32'h31_21_11_01, 4'b0100, 1'b1, 8'h21);
    add_busy(4'b1111, 4'b0100, 1'b0, 32'h31_22_11_01, 4'b0100, 1'b1, 8'h22);
    add_idle(4'b1111, 4'b0000, 32'h31_21_11_01, 1'b0);
    add_busy(4'b1111, 4'b0000, 1'b0, 32'h31_21_11_01, 4'b1000, 1'b1, 8'h31);
    add_busy(4'b1111, 4'b1000, 1'b0, 32'h32_21_11_01, 4'b1000, 1'b1, 8'h32);
    add_idle(4'b1111, 4'b0000, 32'h31_21_11_01, 1'b0);
    add_busy(4'b1111, 4'b0000, 1'b0, 32'h31_21_11_01, 4'b0001, 1'b1, 8'h01);
    add_busy(4'b1111, 4'b0001, 1'b0, 32'h31_21_11_02, 4'b0001, 1'b1, 8'h02);
    add_idle(4'b0000, 4'b0000, 32'h0, 1'b0);
    run("rr");

    // full backpressure for 3 cycles, then a valid gap; grant held throughout
    add_idle(4'b0010, 4'b0000, 32'h00_00_11_00, 1'b0);
    add_busy(4'b0010, 4'b0000, 1'b0, 32'h00_00_11_00, 4'b0010, 1'b1, 8'h11);
    add_busy(4'b0010, 4'b0000, 1'b1, 32'h00_00_12_00, 4'b0010, 1'b0, 8'h12);
    add_busy(4'b0010, 4'b0000, 1'b1, 32'h00_00_12_00, 4'b0010, 1'b0, 8'h12);
    add_busy(4'b0010, 4'b0000, 1'b1, 32'h00_00_12_00, 4'b0010, 1'b0, 8'h12);
    add_busy(4'b0000, 4'b0000, 1'b0, 32'h00_00_12_00, 4'b0010, 1'b0, 8'h12);
    add_busy(4'b0010, 4'b0000, 1'b0, 32'h00_00_12_00, 4'b0010, 1'b1, 8'h12);
    add_busy(4'b0010, 4'b0010, 1'b0, 32'h00_00_13_00, 4'b0010, 1'b1, 8'h13);
    add_idle(4'b0000, 4'b0000, 32'h0, 1'b0);
    run("full");

    // burst limit: requester 1 sends 6 words, forced release after 4;
    // requester 0 then wins over 1, showing rr_ptr moved to 2
    add_idle(4'b0010, 4'b0000, 32'h00_00_11_00, 1'b0);
    add_busy(4'b0010, 4'b0000, 1'b0, 32'h00_00_11_00, 4'b0010, 1'b1, 8'h11);
    add_busy(4'b0010, 4'b0000, 1'b0, 32'h00_00_12_00, 4'b0010, 1'b1, 8'h12);
    add_busy(4'b0010, 4'b0000, 1'b0, 32'h00_00_13_00, 4'b0010, 1'b1, 8'h13);
    add_busy(4'b0010, 4'b0000, 1'b0, 32'h00_00_14_00, 4'b0010, 1'b1, 8'h14);
    add_idle(4'b0011, 4'b0001, 32'h00_00_15_01, 1'b1);
    add_busy(4'b0011, 4'b0001, 1'b0, 32'h00_00_15_01, 4'b0001, 1'b1, 8'h01);
    add_idle(4'b0010, 4'b0000, 32'h00_00_15_00, 1'b0);
    add_busy(4'b0010, 4'b0000, 1'b0, 32'h00_00_15_00, 4'b0010, 1'b1, 8'h15);
    add_busy(4'b0010, 4'b0010, 1'b0, 32'h00_00_16_00, 4'b0010, 1'b1, 8'h16);
    add_idle(4'b0000, 4'b0000, 32'h0, 1'b0);
    run("burst");

    // last on the limit word: normal release, no burst_err
    add_idle(4'b1000, 4'b0000, 32'h31_00_00_00, 1'b0);
    add_busy(4'b1000, 4'b0000, 1'b0, 32'h31_00_00_00, 4'b1000, 1'b1, 8'h31);
    add_busy(4'b1000, 4'b0000, 1'b0, 32'h32_00_00_00, 4'b1000, 1'b1, 8'h32);
    add_busy(4'b1000, 4'b0000, 1'b0, 32'h33_00_00_00, 4'b1000, 1'b1, 8'h33);
    add_busy(4'b1000, 4'b1000, 1'b0, 32'h34_00_00_00, 4'b1000, 1'b1, 8'h34);
    add_idle(4'b0000, 4'b0000, 32'h0, 1'b0);
    add_idle(4'b0000, 4'b0000, 32'h0, 1'b0);
    run("limit_last");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
